reorder_buffer: RTL and testbench
=================================

# reorder_buffer

In-order commit stage sitting directly upstream of the register file in the out-of-order core. Dispatch allocates one entry per destination-writing instruction and gets a tag. Functional units return results on the common data bus (CDB) by tag, in any order. The buffer retires entries strictly in program order and drives the register file write port (`we`, `wa`, `wd`) with one write per cycle at most.

## Interface

Parameters:
- `DEPTH`, default 8: number of entries; must be a power of two, at least 2.
- `TAG_W`, default `$clog2(DEPTH)`: tag width.

Ports:
- `clk_in`, input, 1: clock; all state updates on the rising edge.
- `rst_n_in`, input, 1: reset, asynchronous and active-low.
- `alloc_valid_in`, input, 1: dispatch requests an entry this cycle.
- `alloc_rd_in`, input, 5: destination architectural register for the new entry.
- `alloc_ready_out`, output, 1: an entry is free; allocation is accepted when this and `alloc_valid_in` are both high.
- `alloc_tag_out`, output, TAG_W: tag assigned to an allocation accepted this cycle; equals the tail index.
- `cdb_valid_in`, input, 1: a result is being broadcast.
- `cdb_tag_in`, input, TAG_W: entry the result belongs to.
- `cdb_data_in`, input, 32: result value.
- `flush_in`, input, 1: synchronous discard of all entries.
- `commit_we_out`, output, 1: register-file write enable; a one-cycle pulse per retired entry.
- `commit_wa_out`, output, 5: register-file write address.
- `commit_wd_out`, output, 32: register-file write data.
- `count_out`, output, TAG_W+1: number of occupied entries.
- `empty_out`, output, 1: high when `count_out` is 0.

## Operation

- **Per-entry state:** `valid`, `done`, `rd[4:0]`, `data[31:0]`.
- **Pointers:** head and tail are TAG_W+1 bits wide. The MSB distinguishes full from empty; the low bits index the entries and wrap naturally from DEPTH-1 to 0.
- **Allocate:**
  - On an accepted handshake, the entry at the tail is written with `valid=1`, `done=0`, `rd=alloc_rd_in`, and the tail increments.
  - `alloc_ready_out = (count < DEPTH)` and is computed from registered state only. A commit in the same cycle does not free a slot for that cycle's allocation.
- **CDB:**
  - When `cdb_valid_in` is high and the addressed entry is valid, that entry gets `data=cdb_data_in` and `done=1`.
  - A broadcast to an invalid entry is ignored.
  - A second broadcast to an already-done entry overwrites its data.
- **Commit:**
  - When the head entry is valid and done, the head retires: the entry is cleared and the head increments.
  - The registered outputs take `commit_wa_out=rd`, `commit_wd_out=data`, and `commit_we_out=(rd!=0)`.
  - Writes to x0 retire silently: the head advances, but no write enable is issued.
- **Simultaneous events:**
  - Allocate, CDB, and commit may all occur in the same cycle.
  - `count_out` changes by (alloc − commit), so it is unchanged when one of each occurs.
  - A CDB broadcast whose tag equals the tail being allocated this cycle is ignored, because that entry was not yet valid.
- **Flush:**
  - Flush has priority over allocate, CDB, and commit in the same cycle.
  - At the next edge: all `valid` bits are cleared, head = tail = 0, and `commit_we_out` = 0.
  - `commit_wa_out` and `commit_wd_out` hold their previous values.
  - The next allocation receives tag 0.
- **Reset (asserted):** all `valid` and `done` bits clear, head = tail = 0, `commit_we_out` = 0, `commit_wa_out` = 0, `commit_wd_out` = 0.
  - Resulting outputs: `count_out` = 0, `empty_out` = 1, `alloc_ready_out` = 1, `alloc_tag_out` = 0.
  - Reset asserted mid-operation discards all entries immediately, with no commit pulse.

## Timing

- `alloc_tag_out`, `alloc_ready_out`, `count_out`, and `empty_out` are combinational from registered pointers; they have no combinational path from any input.
- Commit outputs are registered.
  - A CDB write to the head at edge k sets `done`.
  - The head retires at edge k+1, so `commit_we_out` is high in the cycle after edge k+1.
  - Without bypass, the result-to-register-file latency is 2 cycles.
- Back-to-back done entries retire one per cycle, giving consecutive `commit_we_out` pulses.
- An entry allocated at edge k can be completed by the CDB from cycle k+1 onward.

## Configuration

- `ROB_CDB_BYPASS_EN`
  - **Defined:** a CDB broadcast targeting the valid, not-done head entry retires that entry at the same edge, using `cdb_data_in` directly. `commit_we_out` is then high in the cycle after edge k, giving a 1-cycle latency. Other entries behave unchanged.
  - **Undefined:** no bypass; the 2-cycle latency above applies.

## Test plan

- **Reset:** pulse `rst_n_in` low mid-run with 3 entries occupied -> `count_out`=0, `empty_out`=1, `alloc_ready_out`=1, `alloc_tag_out`=0, `commit_we_out`=0, and no pulses afterwards.
- **Out-of-order completion:** allocate rd=5, 6, 7 (tags 0, 1, 2); broadcast tag2=0x33, then tag0=0x11, then tag1=0x22 -> writes x5=0x11, then x6=0x22 and x7=0x33 on consecutive cycles after tag1; final `count_out`=0.
- **Full:** DEPTH=8; make 9 back-to-back allocation requests -> `alloc_ready_out`=0 after the 8th, the 9th is not accepted, `count_out`=8; complete tag0 -> one commit, and `alloc_ready_out`=1 the following cycle.
- **x0:** allocate rd=0; broadcast 0xDEAD -> the head advances, `count_out` goes 1→0, `commit_we_out` never asserts.
- **Flush:** 4 entries occupied, tags 0 and 1 done; assert `flush_in` together with `alloc_valid_in` and `cdb_valid_in` -> next cycle `count_out`=0 and no commit pulse; the next allocation gets tag 0.
- **Wrap and simultaneous events:** run 20 instructions with allocate, complete, and commit overlapping every cycle -> tags wrap 7→0, `count_out` stays constant when alloc and commit coincide, and every write matches its `rd` and data in program order.

Source files
------------

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order commit of CDB-completed results to the register file (optional ROB_CDB_BYPASS_EN)
module reorder_buffer #(
  parameter int DEPTH = 8,
  parameter int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             alloc_valid_in,
  input  logic [4:0]       alloc_rd_in,
  output logic             alloc_ready_out,
  output logic [TAG_W-1:0] alloc_tag_out,
  input  logic             cdb_valid_in,
  input  logic [TAG_W-1:0] cdb_tag_in,
  input  logic [31:0]      cdb_data_in,
  input  logic             flush_in,
  output logic             commit_we_out,
  output logic [4:0]       commit_wa_out,
  output logic [31:0]      commit_wd_out,
  output logic [TAG_W:0]   count_out,
  output logic             empty_out
);
  logic [TAG_W:0] head, tail;
  logic [DEPTH-1:0] valid, done;
  logic [4:0] rd_q [DEPTH];
  logic [31:0] data_q [DEPTH];
  logic [TAG_W-1:0] hi, ti;
  logic alloc_go, cdb_hit, byp, retire;
  logic [31:0] ret_data;
  assign hi = head[TAG_W-1:0];
  assign ti = tail[TAG_W-1:0];
  assign count_out = tail - head;
  assign empty_out = count_out == '0;
  assign alloc_ready_out = ~count_out[TAG_W];
  assign alloc_tag_out = ti;
  assign alloc_go = alloc_valid_in & alloc_ready_out;
  assign cdb_hit = cdb_valid_in & valid[cdb_tag_in];
`ifdef ROB_CDB_BYPASS_EN
  assign byp = cdb_hit & (cdb_tag_in == hi) & ~done[hi];
`else
  assign byp = 1'b0;
`endif
  assign retire = valid[hi] & (done[hi] | byp);
  assign ret_data = byp ? cdb_data_in : data_q[hi];
  // entry status and pointers; flush wins over allocate, CDB and commit
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      valid <= '0;
      done <= '0;
      head <= '0;
      tail <= '0;
    end else if (flush_in) begin
      valid <= '0;
      done <= '0;
      head <= '0;
      tail <= '0;
    end else begin
      if (alloc_go) begin
        valid[ti] <= 1'b1;
        done[ti] <= 1'b0;
        tail <= tail + 1'b1;
      end
      if (cdb_hit) done[cdb_tag_in] <= 1'b1;
      if (retire) begin
        valid[hi] <= 1'b0;
        done[hi] <= 1'b0;
        head <= head + 1'b1;
      end
    end
  end
  // entry payload; only meaningful while the matching valid bit is set
  always_ff @(posedge clk_in) begin
    if (alloc_go) rd_q[ti] <= alloc_rd_in;
    if (cdb_hit) data_q[cdb_tag_in] <= cdb_data_in;
  end
  // registered register-file write port; x0 retires without a write enable
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      commit_we_out <= 1'b0;
      commit_wa_out <= '0;
      commit_wd_out <= '0;
    end else if (flush_in) begin
      commit_we_out <= 1'b0;
    end else begin
      commit_we_out <= retire & (rd_q[hi] != 5'd0);
      if (retire) begin
        commit_wa_out <= rd_q[hi];
        commit_wd_out <= ret_data;
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed vector table plus reset, full and wrap sequences
module tb_reorder_buffer;
  localparam int DEPTH = 8;
  localparam int TAG_W = 3;
  logic clk_in = 1'b0;
  logic rst_n_in = 1'b0;
  logic alloc_valid_in = 1'b0;
  logic [4:0] alloc_rd_in = '0;
  logic cdb_valid_in = 1'b0;
  logic [TAG_W-1:0] cdb_tag_in = '0;
  logic [31:0] cdb_data_in = '0;
  logic flush_in = 1'b0;
  logic alloc_ready_out, commit_we_out, empty_out;
  logic [TAG_W-1:0] alloc_tag_out;
  logic [4:0] commit_wa_out;
  logic [31:0] commit_wd_out;
  logic [TAG_W:0] count_out;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic av; logic [4:0] rd; logic cv; logic [2:0] tg; logic [31:0] d; logic fl;
    logic we; logic cw; logic [4:0] wa; logic [31:0] wd; int cnt; int tag;
  } vec_t;
  vec_t v[22];
  always #5 clk_in = ~clk_in;
  reorder_buffer #(.DEPTH(DEPTH)) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .alloc_valid_in(alloc_valid_in), .alloc_rd_in(alloc_rd_in),
    .alloc_ready_out(alloc_ready_out), .alloc_tag_out(alloc_tag_out),
    .cdb_valid_in(cdb_valid_in), .cdb_tag_in(cdb_tag_in), .cdb_data_in(cdb_data_in),
    .flush_in(flush_in),
    .commit_we_out(commit_we_out), .commit_wa_out(commit_wa_out), .commit_wd_out(commit_wd_out),
    .count_out(count_out), .empty_out(empty_out)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic drive(input logic av, input logic [4:0] rd, input logic cv, input logic [2:0] tg, input logic [31:0] d, input logic fl);
    alloc_valid_in = av;
    alloc_rd_in = rd;
    cdb_valid_in = cv;
    cdb_tag_in = tg;
    cdb_data_in = d;
    flush_in = fl;
  endtask
  task automatic step;
    @(posedge clk_in);
    #1;
  endtask
  function automatic vec_t mk(input logic av, input int rd, input logic cv, input int tg, input int d, input logic fl,
                              input logic we, input logic cw, input int wa, input int wd, input int cnt, input int tag);
    vec_t r;
    r.av = av; r.rd = 5'(rd); r.cv = cv; r.tg = 3'(tg); r.d = 32'(d); r.fl = fl;
    r.we = we; r.cw = cw; r.wa = 5'(wa); r.wd = 32'(wd); r.cnt = cnt; r.tag = tag;
    return r;
  endfunction
  function automatic logic [4:0] rdf(input int j);
    return 5'(j % 31 + 1);
  endfunction
  initial begin
    v[0]  = mk(1, 5, 0, 0, 0,      0, 0, 1, 0, 0,      1, 1);
    v[1]  = mk(1, 6, 0, 0, 0,      0, 0, 1, 0, 0,      2, 2);
    v[2]  = mk(1, 7, 0, 0, 0,      0, 0, 1, 0, 0,      3, 3);
    v[3]  = mk(0, 0, 1, 2, 'h33,   0, 0, 1, 0, 0,      3, 3);
    v[4]  = mk(0, 0, 1, 0, 'h11,   0, 0, 1, 0, 0,      3, 3);
    v[5]  = mk(0, 0, 1, 1, 'h22,   0, 1, 1, 5, 'h11,   2, 3);
    v[6]  = mk(0, 0, 0, 0, 0,      0, 1, 1, 6, 'h22,   1, 3);
    v[7]  = mk(0, 0, 0, 0, 0,      0, 1, 1, 7, 'h33,   0, 3);
    v[8]  = mk(0, 0, 0, 0, 0,      0, 0, 1, 7, 'h33,   0, 3);
    v[9]  = mk(1, 0, 0, 0, 0,      0, 0, 1, 7, 'h33,   1, 4);
    v[10] = mk(0, 0, 1, 3, 'hDEAD, 0, 0, 1, 7, 'h33,   1, 4);
    v[11] = mk(0, 0, 0, 0, 0,      0, 0, 0, 0, 0,      0, 4);
    v[12] = mk(0, 0, 0, 0, 0,      0, 0, 0, 0, 0,      0, 4);
    v[13] = mk(1, 1, 0, 0, 0,      0, 0, 0, 0, 0,      1, 5);
    v[14] = mk(1, 2, 0, 0, 0,      0, 0, 0, 0, 0,      2, 6);
    v[15] = mk(1, 3, 1, 5, 'h55,   0, 0, 0, 0, 0,      3, 7);
    v[16] = mk(1, 4, 1, 4, 'h44,   0, 0, 0, 0, 0,      4, 0);
    v[17] = mk(1, 9, 1, 6, 'h66,   1, 0, 0, 0, 0,      0, 0);
    v[18] = mk(0, 0, 0, 0, 0,      0, 0, 0, 0, 0,      0, 0);
    v[19] = mk(1, 10, 0, 0, 0,     0, 0, 0, 0, 0,      1, 1);
    v[20] = mk(0, 0, 1, 0, 'hAB,   0, 0, 0, 0, 0,      1, 1);
    v[21] = mk(0, 0, 0, 0, 0,      0, 1, 1, 10, 'hAB,  0, 1);
    step;
    step;
    chk("rst.count", 32'(count_out), 0);
    chk("rst.empty", 32'(empty_out), 1);
    chk("rst.ready", 32'(alloc_ready_out), 1);
    chk("rst.tag", 32'(alloc_tag_out), 0);
    chk("rst.we", 32'(commit_we_out), 0);
    chk("rst.wa", 32'(commit_wa_out), 0);
    chk("rst.wd", commit_wd_out, 0);
    rst_n_in = 1'b1;
    for (int i = 0; i < 22; i++) begin
      drive(v[i].av, v[i].rd, v[i].cv, v[i].tg, v[i].d, v[i].fl);
      step;
      chk($sformatf("v%0d.we", i), 32'(commit_we_out), 32'(v[i].we));
      chk($sformatf("v%0d.count", i), 32'(count_out), 32'(v[i].cnt));
      chk($sformatf("v%0d.empty", i), 32'(empty_out), 32'(v[i].cnt == 0));
      chk($sformatf("v%0d.tag", i), 32'(alloc_tag_out), 32'(v[i].tag));
      chk($sformatf("v%0d.ready", i), 32'(alloc_ready_out), 1);
      if (v[i].cw) begin
        chk($sformatf("v%0d.wa", i), 32'(commit_wa_out), 32'(v[i].wa));
        chk($sformatf("v%0d.wd", i), commit_wd_out, v[i].wd);
      end
    end
    for (int i = 0; i < 3; i++) begin
      drive(1, 5'(20 + i), 0, 0, 0, 0);
      step;
    end
    drive(0, 0, 0, 0, 0, 0);
    chk("mid.count", 32'(count_out), 3);
    #2 rst_n_in = 1'b0;
    #1;
    chk("mid.count0", 32'(count_out), 0);
    chk("mid.empty", 32'(empty_out), 1);
    chk("mid.ready", 32'(alloc_ready_out), 1);
    chk("mid.tag", 32'(alloc_tag_out), 0);
    chk("mid.we", 32'(commit_we_out), 0);
    step;
    rst_n_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1, 3'(i), 32'h77, 0);
      step;
      chk($sformatf("post_rst%0d.we", i), 32'(commit_we_out), 0);
      chk($sformatf("post_rst%0d.count", i), 32'(count_out), 0);
    end
    for (int i = 0; i < 9; i++) begin
      drive(1, 5'(i + 1), 0, 0, 0, 0);
      step;
      chk($sformatf("full%0d.count", i), 32'(count_out), 32'(i + 1 < 8 ? i + 1 : 8));
      chk($sformatf("full%0d.ready", i), 32'(alloc_ready_out), 32'(i + 1 < 8));
    end
    chk("full.tag", 32'(alloc_tag_out), 0);
    drive(1, 5'd30, 1, 0, 32'h100, 0);
    step;
    chk("full_cdb.count", 32'(count_out), 8);
    chk("full_cdb.ready", 32'(alloc_ready_out), 0);
    chk("full_cdb.we", 32'(commit_we_out), 0);
    drive(1, 5'd30, 0, 0, 0, 0);
    step;
    chk("full_commit.we", 32'(commit_we_out), 1);
    chk("full_commit.wa", 32'(commit_wa_out), 1);
    chk("full_commit.wd", commit_wd_out, 32'h100);
    chk("full_commit.count", 32'(count_out), 7);
    chk("full_commit.ready", 32'(alloc_ready_out), 1);
    drive(0, 0, 0, 0, 0, 0);
    rst_n_in = 1'b0;
    step;
    rst_n_in = 1'b1;
    for (int c = 0; c < 24; c++) begin
      int a, r;
      if (c < 20) chk($sformatf("wrap%0d.tag", c), 32'(alloc_tag_out), 32'(c % 8));
      drive(c < 20, rdf(c), c >= 1 && c <= 20, 3'((c - 1) % 8), 32'h1000 + 32'(c - 1), 0);
      step;
      a = c + 1 < 20 ? c + 1 : 20;
      r = c - 1 < 0 ? 0 : (c - 1 > 20 ? 20 : c - 1);
      chk($sformatf("wrap%0d.count", c), 32'(count_out), 32'(a - r));
      chk($sformatf("wrap%0d.we", c), 32'(commit_we_out), 32'(c >= 2 && c <= 21));
      if (c >= 2 && c <= 21) begin
        chk($sformatf("wrap%0d.wa", c), 32'(commit_wa_out), 32'(rdf(c - 2)));
        chk($sformatf("wrap%0d.wd", c), commit_wd_out, 32'h1000 + 32'(c - 2));
      end
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
